// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array with a registered read port.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; clears only the read-data register
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; loads rdata from mem[raddr]
//   raddr : read address
//   rdata : registered read data, holds its value when re is low
module fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/write_fifo.sv
// write_fifo: buffers the arbiter's write stream without ever stalling it.
//   i_clk      : rising-edge clock
//   i_reset    : synchronous active-high reset
//   i_we       : write strobe from the arbiter
//   i_data     : write data, sampled when i_we=1
//   i_re       : read request from the consumer
//   o_data     : registered read data, held until the next accepted read
//   o_rvalid   : o_data carries a newly read word this cycle
//   o_records  : number of stored words
//   o_empty    : o_records == 0 (registered)
//   o_full     : o_records == DEPTH (registered)
//   o_overflow : sticky, a write was dropped since reset
module write_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_we,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_re,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_rvalid,
    output logic [$clog2(DEPTH+1)-1:0] o_records,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] records_q, records_d;
    logic          empty_q, full_q, overflow_q, rvalid_q;
    logic          wr_ok, rd_ok;

    // A read while full frees a slot, so the write is still accepted.
    assign rd_ok = i_re && !empty_q;
    assign wr_ok = i_we && (!full_q || rd_ok);

    always_comb begin
        records_d = records_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   records_d = records_q + CW'(1);
            2'b01:   records_d = records_q - CW'(1);
            default: records_d = records_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            records_q  <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            records_q <= records_d;
            empty_q   <= (records_d == '0);
            full_q    <= (records_d == FullCnt);
            rvalid_q  <= rd_ok;
            if (i_we && !wr_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (i_clk),
        .reset (i_reset),
        .we    (wr_ok && !i_reset),
        .waddr (wptr_q),
        .wdata (i_data),
        .re    (rd_ok && !i_reset),
        .raddr (rptr_q),
        .rdata (o_data)
    );

    assign o_rvalid   = rvalid_q;
    assign o_records  = records_q;
    assign o_empty    = empty_q;
    assign o_full     = full_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_write_fifo.sv
// Self-checking bench for write_fifo (DEPTH=8, DATA_W=8).
module tb_write_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       we, re;
    logic [7:0] din;
    logic [7:0] q;
    logic       rvalid, empty, full, ovf;
    logic [3:0] records;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    write_fifo #(
        .DEPTH  (8),
        .DATA_W (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_we       (we),
        .i_data     (din),
        .i_re       (re),
        .o_data     (q),
        .o_rvalid   (rvalid),
        .o_records  (records),
        .o_empty    (empty),
        .o_full     (full),
        .o_overflow (ovf)
    );

    typedef struct {
        logic       we;
        logic [7:0] d;
        logic       re;
        logic [3:0] rec;
        logic       emp;
        logic       ful;
        logic       rv;
        logic [7:0] q;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] model[$];

    function automatic vec_t mk(logic w, logic [7:0] d, logic r, logic [3:0] rec,
                                logic emp, logic ful, logic rv, logic [7:0] qq, logic o);
        vec_t v;
        v.we = w; v.d = d; v.re = r; v.rec = rec; v.emp = emp;
        v.ful = ful; v.rv = rv; v.q = qq; v.ovf = o;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(logic w, logic [7:0] d, logic r);
        @(negedge clk);
        we = w; din = d; re = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(string tag, logic [3:0] rec, logic emp, logic ful);
        check({tag, ".records"}, 32'(records), 32'(rec));
        check({tag, ".empty"}, 32'(empty), 32'(emp));
        check({tag, ".full"}, 32'(full), 32'(ful));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        we = 1'b0; re = 1'b0; din = '0;
    endtask

    task automatic fill(int base);
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(base + k), 1'b0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; din = '0;
        do_reset();
        #1;
        check_state("reset", 4'd0, 1'b1, 1'b0);
        check("reset.rvalid", 32'(rvalid), 0);
        check("reset.overflow", 32'(ovf), 0);
        check("reset.data", 32'(q), 0);

        // Fill, drain, read-while-empty, write+read while empty.
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 8'(k), 0, 4'(k), 0, (k == 8), 0, 8'h00, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 8'h00, 1, 4'(8 - k), (k == 8), 0, 1, 8'(k), 0));
        vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 0, 0, 8'h08, 0));
        vecs.push_back(mk(1, 8'h77, 1, 4'd1, 0, 0, 0, 8'h08, 0));
        vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 0, 1, 8'h77, 0));
        vecs.push_back(mk(0, 8'h00, 0, 4'd0, 1, 0, 0, 8'h77, 0));

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].d, vecs[i].re);
            check($sformatf("vec%0d.records", i), 32'(records), 32'(vecs[i].rec));
            check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].ful));
            check($sformatf("vec%0d.rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
            check($sformatf("vec%0d.data", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d.overflow", i), 32'(ovf), 32'(vecs[i].ovf));
        end

        // Full: write 0x55 with a read -> both accepted, 0x55 comes out last.
        fill(8'h00);
        step(1'b1, 8'h55, 1'b1);
        check_state("fullwr", 4'd8, 1'b0, 1'b1);
        check("fullwr.overflow", 32'(ovf), 0);
        check("fullwr.data", 32'(q), 32'h01);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("fullwr.drain%0d", k), 32'(q), (k == 7) ? 32'h55 : 32'(k + 2));
            check($sformatf("fullwr.rv%0d", k), 32'(rvalid), 1);
        end
        check_state("fullwr.end", 4'd0, 1'b1, 1'b0);

        // Overflow: drop 0xAA, flag sticks through the drain.
        fill(8'h00);
        step(1'b1, 8'hAA, 1'b0);
        check("ovf.flag", 32'(ovf), 1);
        check_state("ovf", 4'd8, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("ovf.drain%0d", k), 32'(q), 32'(k + 1));
        end
        step(1'b0, 8'h00, 1'b0);
        check("ovf.sticky", 32'(ovf), 1);
        check_state("ovf.end", 4'd0, 1'b1, 1'b0);
        do_reset();
        #1;
        check("ovf.cleared", 32'(ovf), 0);

        // Wrap-around: write, write, read, read ... occupancy never above 2.
        model.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % 4 < 2) begin
                step(1'b1, 8'(8'h30 + i), 1'b0);
                model.push_back(8'(8'h30 + i));
            end else begin
                logic [7:0] exp;
                exp = model.pop_front();
                step(1'b0, 8'h00, 1'b1);
                check($sformatf("wrap.data%0d", i), 32'(q), 32'(exp));
                check($sformatf("wrap.rv%0d", i), 32'(rvalid), 1);
            end
            check($sformatf("wrap.records%0d", i), 32'(records), 32'(model.size()));
        end

        // Two-writer traffic shaped like the arbiter's output.
        model.delete();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] w;
            w = (k % 2 == 1) ? 8'(8'hB0 + k) : 8'(8'hA0 + k);
            step(1'b1, w, 1'b0);
            model.push_back(w);
        end
        step(1'b0, 8'h00, 1'b0);
        check("arb.records", 32'(records), 4);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp;
            exp = model.pop_front();
            step(1'b0, 8'h00, 1'b1);
            check($sformatf("arb.data%0d", k), 32'(q), 32'(exp));
            check($sformatf("arb.src%0d", k), 32'(q[7:4] == 4'hA || q[7:4] == 4'hB), 1);
        end

        // Reset mid-operation with a write and read presented in the reset cycle.
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hC0 + k), 1'b0);
        @(negedge clk);
        rst = 1'b1; we = 1'b1; re = 1'b1; din = 8'hEE;
        @(posedge clk);
        #1;
        check_state("midrst", 4'd0, 1'b1, 1'b0);
        check("midrst.rvalid", 32'(rvalid), 0);
        check("midrst.data", 32'(q), 0);
        @(negedge clk);
        rst = 1'b0; we = 1'b0; re = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        check("midrst.readempty", 32'(rvalid), 0);
        check_state("midrst.after", 4'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
